// File: rtl/skein_link_pkg.sv
// Shared FPGA<->host link definitions: frame header bytes, response codes and
// the response transmitter state encoding.
// Optional feature macro: TX_CHECKSUM_EN adds the trailing checksum state.
package skein_link_pkg;

  localparam logic [7:0] HDR0       = 8'd100;  // 'd'
  localparam logic [7:0] HDR1       = 8'd52;   // '4'
  localparam logic [7:0] RSP_PING   = 8'd112;  // 'p'
  localparam logic [7:0] RSP_RESULT = 8'd114;  // 'r'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_CODE,
    ST_PAYLOAD
`ifdef TX_CHECKSUM_EN
    ,
    ST_CSUM
`endif
  } tx_state_e;

  typedef enum logic {
    KIND_PING,
    KIND_RESULT
  } frame_kind_e;

endpackage

// File: rtl/response_transmitter_if.sv
// Handshake bundle between the search core / command decoder, the response
// transmitter and the UART TX. master = transmitter side, slave = environment.
interface response_transmitter_if #(
  parameter int NONCE_BYTES = 8,
  parameter int SCORE_BYTES = 2
) ();

  logic                     ping_i;
  logic                     result_valid_i;
  logic                     result_ready_o;
  logic [8*NONCE_BYTES-1:0] result_nonce_i;
  logic [8*SCORE_BYTES-1:0] result_score_i;
  logic                     tx_valid_o;
  logic [7:0]               tx_data_o;
  logic                     tx_ready_i;
  logic                     busy_o;

  modport master (
    input  ping_i, result_valid_i, result_nonce_i, result_score_i, tx_ready_i,
    output result_ready_o, tx_valid_o, tx_data_o, busy_o
  );

  modport slave (
    output ping_i, result_valid_i, result_nonce_i, result_score_i, tx_ready_i,
    input  result_ready_o, tx_valid_o, tx_data_o, busy_o
  );

endinterface

// File: rtl/response_transmitter.sv
// Host-bound framing engine: turns ping requests and search results into
// "d4"-headed byte frames fed to the UART TX one byte per handshake.
// Optional feature macro: TX_CHECKSUM_EN appends an XOR checksum byte
// (code byte and payload) to every frame.
//
// state   | meaning
// IDLE    | no frame; picks pending ping first, then a full result slot
// HDR0    | presenting 0x64
// HDR1    | presenting 0x34
// CODE    | presenting response code ('p' or 'r')
// PAYLOAD | presenting score then nonce bytes, MSB first, indexed by byte_cnt
// CSUM    | presenting checksum byte (TX_CHECKSUM_EN only)
module response_transmitter
  import skein_link_pkg::*;
#(
  parameter int NONCE_BYTES = 8,
  parameter int SCORE_BYTES = 2
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  response_transmitter_if.master bus
);

  localparam int TOTAL = SCORE_BYTES + NONCE_BYTES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int SEL_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

  tx_state_e              state_q, state_d;
  frame_kind_e            kind_q, kind_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic                   ping_pending_q;
  logic                   result_full_q;
  logic [TOTAL-1:0][7:0]  shadow_q;
  logic                   accept;
  logic                   ping_start;
  logic                   result_done;
  logic [SEL_W-1:0]       byte_sel;
  logic [7:0]             code_byte;
  logic [7:0]             tx_data;

  assign accept    = bus.tx_valid_o && bus.tx_ready_i;
  assign code_byte = (kind_q == KIND_PING) ? RSP_PING : RSP_RESULT;

  // FSM state, frame kind and payload byte counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_PING;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next-state: each non-idle state advances only on a UART accept
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    byte_cnt_d  = byte_cnt_q;
    ping_start  = 1'b0;
    result_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ping_pending_q) begin
          state_d    = ST_HDR0;
          kind_d     = KIND_PING;
          ping_start = 1'b1;
        end else if (result_full_q) begin
          state_d = ST_HDR0;
          kind_d  = KIND_RESULT;
        end
      end
      ST_HDR0: if (accept) state_d = ST_HDR1;
      ST_HDR1: if (accept) state_d = ST_CODE;
      ST_CODE: begin
        if (accept) begin
          if (kind_q == KIND_PING) begin
`ifdef TX_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            state_d    = ST_PAYLOAD;
            byte_cnt_d = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          if (byte_cnt_q == CNT_LAST) begin
`ifdef TX_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d     = ST_IDLE;
            result_done = 1'b1;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
`ifdef TX_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d     = ST_IDLE;
          result_done = (kind_q == KIND_RESULT);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Ping request flag; a new request wins over the clear at frame start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ping_pending_q <= 1'b0;
    end else if (bus.ping_i) begin
      ping_pending_q <= 1'b1;
    end else if (ping_start) begin
      ping_pending_q <= 1'b0;
    end
  end

  // Result slot: captured on handshake, freed on the frame's final accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_full_q <= 1'b0;
      shadow_q      <= '0;
    end else if (bus.result_valid_i && !result_full_q) begin
      result_full_q <= 1'b1;
      shadow_q      <= {bus.result_score_i, bus.result_nonce_i};
    end else if (result_done) begin
      result_full_q <= 1'b0;
    end
  end

`ifdef TX_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of code and payload bytes as they are accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= 8'h00;
    end else if (accept && state_q == ST_CODE) begin
      csum_q <= code_byte;
    end else if (accept && state_q == ST_PAYLOAD) begin
      csum_q <= csum_q ^ tx_data;
    end
  end
`endif

  // Output byte mux; out-of-range counts select byte 0 rather than overrun
  always_comb begin
    tx_data  = 8'h00;
    byte_sel = '0;
    if (byte_cnt_q < CNT_W'(TOTAL)) begin
      byte_sel = SEL_W'(TOTAL - 1) - SEL_W'(byte_cnt_q);
    end
    case (state_q)
      ST_HDR0:    tx_data = HDR0;
      ST_HDR1:    tx_data = HDR1;
      ST_CODE:    tx_data = code_byte;
      ST_PAYLOAD: tx_data = shadow_q[byte_sel];
`ifdef TX_CHECKSUM_EN
      ST_CSUM:    tx_data = csum_q;
`endif
      default:    tx_data = 8'h00;
    endcase
  end

  assign bus.tx_data_o      = tx_data;
  assign bus.tx_valid_o     = (state_q != ST_IDLE);
  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.result_ready_o = !result_full_q;

endmodule

// File: doc/response_transmitter.md
# response_transmitter

Host-bound framing engine for the FPGA-to-host serial link. It packs ping replies and search results into framed byte streams, using the same `d` `4` header as host-to-FPGA commands. It feeds the UART transmitter one byte at a time through a valid/ready handshake. It sits between the search core / command decoder and the UART TX.

## Interface
Parameters:
- `NONCE_BYTES`, 8: nonce payload length in bytes, sent MSB first; legal range 1–32.
- `SCORE_BYTES`, 2: score payload length in bytes, sent MSB first; legal range 1–4.

Ports:
- `clk_i` input 1: single clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `ping_i` input 1: one-cycle request for a ping reply frame.
- `result_valid_i` input 1: result offer.
- `result_ready_o` output 1: result slot empty; transfer occurs on `result_valid_i && result_ready_o`.
- `result_nonce_i` input 8*NONCE_BYTES: nonce to report.
- `result_score_i` input 8*SCORE_BYTES: score (hash distance) to report.
- `tx_valid_o` output 1: `tx_data_o` holds a byte to send.
- `tx_data_o` output 8: byte to send.
- `tx_ready_i` input 1: UART accepts a byte; transfer occurs on `tx_valid_o && tx_ready_i`.
- `busy_o` output 1: a frame is in progress (FSM not IDLE).

## Operation
- Frames:
  - Ping reply: 0x64, 0x34, 0x70 (`p`).
  - Result: 0x64, 0x34, 0x72 (`r`), then score bytes, then nonce bytes.
- `ping_pending` flag:
  - Set by `ping_i`; cleared when a ping frame starts.
  - A set and a clear in the same cycle leaves the flag set.
  - Repeated pings while pending coalesce into one frame.
- Result slot:
  - Shadow register plus `result_full` flag.
  - `result_ready_o` = !`result_full`.
  - The slot is loaded on handshake and is the frame source; the inputs are not re-read.
- FSM states: IDLE, HDR0, HDR1, CODE, PAYLOAD, plus CSUM when configured.
  - IDLE: `ping_pending` → HDR0 with kind=PING. Else `result_full` → HDR0 with kind=RESULT. Ping has priority.
  - HDR0 → HDR1 → CODE: each advances on accept.
  - CODE on accept: PING → IDLE (or CSUM); RESULT → PAYLOAD with `byte_cnt`=0.
  - PAYLOAD: `byte_cnt` counts 0..SCORE_BYTES+NONCE_BYTES-1 and increments on accept. The last accept goes to IDLE (or CSUM).
  - A RESULT frame clears `result_full` on the accept of its final byte.
- Data transfer:
  - `tx_data_o` is a mux of FSM state and `byte_cnt` over the shadow register.
  - The byte-select index never exceeds the payload length.
  - `byte_cnt` width is $clog2(SCORE_BYTES+NONCE_BYTES+1).

## Timing
- Reset values:
  - `tx_valid_o`=0, `tx_data_o`=0x00, `busy_o`=0.
  - `result_ready_o`=1.
  - Pending and full flags 0; FSM in IDLE.
- Latency: `ping_i` or a result handshake at cycle 0 gives `tx_valid_o`=1 with 0x64 in cycle 2.
- Byte pacing:
  - Each byte is presented from the cycle after the previous byte's accept.
  - With `tx_ready_i` held high, one byte goes out per cycle.
- While `tx_valid_o`=1 and `tx_ready_i`=0, `tx_data_o` holds stable and `tx_valid_o` does not drop.
- Slot reuse: `result_ready_o` returns high in the cycle after the final result byte's accept.
- Back-to-back frames: after the final accept the FSM is in IDLE for exactly one cycle, with `tx_valid_o`=0.
- Reset asserted mid-frame: outputs go to reset values immediately; no partial frame resumes.

## Configuration
- `TX_CHECKSUM_EN` defined:
  - Every frame ends with one CSUM byte.
  - CSUM is the XOR of the code byte and all payload bytes; header bytes are excluded.
  - Ping CSUM is 0x70.
  - `result_full` clears on the CSUM accept.
- `TX_CHECKSUM_EN` undefined:
  - No CSUM state or checksum register.
  - Frames end at the code byte (ping) or the last nonce byte (result).

## Structure
- Shared package `skein_link_pkg` holds:
  - Header constants HDR0=8'd100 and HDR1=8'd52.
  - Response codes RSP_PING=8'd112 and RSP_RESULT=8'd114.
  - The FSM state enum.
- The command receiver also uses these header constants.
- No sub-module; the FSM, flags and byte mux form one module.

## Test plan
- Ping with `tx_ready_i`=1:
  - `ping_i` pulse at cycle 0 → 0x64, 0x34, 0x70 in cycles 2–4; `busy_o` falls in cycle 5.
  - With `TX_CHECKSUM_EN`, a fourth byte 0x70 follows.
- Result frame:
  - Stimulus: score 0x01A3, nonce 0x0011223344556677.
  - Response: 0x64, 0x34, 0x72, 0x01, 0xA3, 0x00, 0x11, …, 0x77.
  - `result_ready_o` is low throughout and high in the cycle after 0x77.
- Backpressure: toggle `tx_ready_i` randomly → byte sequence unchanged, and `tx_data_o` stable whenever valid is high and ready is low.
- Priority and coalescing:
  - Stimulus: result offered, three pings, all during an active ping frame.
  - Response: exactly one ping frame, then one result frame; a second result offer sees `result_ready_o`=0.
- Same-cycle set/clear: `ping_i` pulsed in the cycle IDLE starts a ping frame → a second ping frame follows.
- Reset mid-frame: `rst_ni` low after the 5th result byte → `tx_valid_o`=0 and `result_ready_o`=1 asynchronously; the next ping produces a clean 0x64-led frame.
